// File: rtl/pixel_stream_feeder_pkg.sv
// Shared types and constants for the LCD pixel feed path.
package lcd_pkg;

   localparam int unsigned COORD_W = 11;

   typedef logic [23:0] pixel_t;

   localparam pixel_t FILL_COLOR_DEF = 24'h000000;

   typedef enum logic [1:0] {
      SEEK,
      FILL,
      WAIT_FRAME,
      STREAM
   } feed_state_e;

   // Active pixels per frame; 22 bits covers 750 x 1334.
   function automatic logic [21:0] frame_pixels(input logic [COORD_W-1:0] w,
                                                input logic [COORD_W-1:0] h);
      return 22'(w) * 22'(h);
   endfunction

endpackage

// File: rtl/pixel_stream_feeder_if.sv
// Valid/ready pixel stream carrying RGB888 beats with a start-of-frame flag.
interface pixel_stream_feeder_if;
   import lcd_pkg::*;

   logic   s_valid;
   logic   s_ready;
   pixel_t s_data;
   logic   s_sof;

   modport master (output s_valid, output s_data, output s_sof, input s_ready);
   modport slave  (input s_valid, input s_data, input s_sof, output s_ready);

endinterface

// File: rtl/sync_fifo_showahead.sv
// Show-ahead FIFO: the head entry is always visible on rd_data.
// Updates on the falling clock edge to line up with the LCD driver.
// A flush may coincide with a write; the written word then lands in slot 0.
module sync_fifo_showahead #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_addr;
   logic             do_wr, do_rd;

   assign level   = wr_ptr_q - rd_ptr_q;
   assign full    = (level == PW'(DEPTH));
   assign empty   = (level == '0);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
   assign do_wr   = wr_en && (flush || !full);
   assign do_rd   = rd_en && !empty && !flush;
   assign wr_addr = flush ? '0 : wr_ptr_q[AW-1:0];

   // Next pointer values; flush restarts both pointers at slot 0.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = do_wr ? PW'(1) : '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // Pointer registers.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, no reset needed.
   always_ff @(negedge clk) begin
      if (do_wr) mem_q[wr_addr] <= wr_data;
   end

endmodule

// File: rtl/pixel_stream_feeder.sv
// Buffers an RGB888 stream and serves zero-latency pixels to the LCD timing
// driver, aligning start-of-frame to pixel (0,0) and resynchronising on
// underflow or frame-length errors.
module pixel_stream_feeder
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned PREFILL    = 512,
   parameter pixel_t      FILL_COLOR = FILL_COLOR_DEF,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                    pclk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    clr_status,
   pixel_stream_feeder_if.slave    s,
   input  logic                    pixel_request,
   input  logic [COORD_W-1:0]      pixel_x,
   input  logic [COORD_W-1:0]      pixel_y,
   input  logic [COORD_W-1:0]      max_x,
   input  logic [COORD_W-1:0]      max_y,
   output pixel_t                  pixel_data,
   output logic                    streaming,
   output logic                    underflow,
   output logic                    sync_err,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [CNT_W-1:0]        underflow_cnt,
   output logic [CNT_W-1:0]        frame_cnt
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);

   feed_state_e      state_q, state_d;
   logic [21:0]      wr_pix_q, wr_pix_d;
   logic [21:0]      rd_pix_q, rd_pix_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] underflow_cnt_q, underflow_cnt_d;
   logic             underflow_q, underflow_d;
   logic             sync_err_q, sync_err_d;

   logic             fifo_wr, fifo_rd, fifo_flush;
   logic             full, empty;
   pixel_t           head;
   logic [21:0]      frame_size;
   logic             accept, start_hit, underrun, frame_err;

   sync_fifo_showahead #(
      .WIDTH (24),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (pclk),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr),
      .wr_data (s.s_data),
      .rd_en   (fifo_rd),
      .rd_data (head),
      .flush   (fifo_flush),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   assign frame_size = frame_pixels(max_x, max_y);
   assign s.s_ready  = rst_n && enable && ((state_q == SEEK) || !full);
   assign accept     = s.s_valid && s.s_ready;
   assign start_hit  = enable && (state_q == WAIT_FRAME) && pixel_request &&
                       (pixel_x == '0) && (pixel_y == '0) && !empty;
   assign underrun   = (state_q == STREAM) && pixel_request && empty;
   assign frame_err  = s.s_sof ? (wr_pix_q != frame_size) : (wr_pix_q == frame_size);
   // The first pixel is popped while still in WAIT_FRAME, so it is shown then.
   assign pixel_data = (((state_q == STREAM) || start_hit) && !empty) ? head : FILL_COLOR;

   assign streaming     = (state_q == STREAM);
   assign underflow     = underflow_q;
   assign sync_err      = sync_err_q;
   assign underflow_cnt = underflow_cnt_q;
   assign frame_cnt     = frame_cnt_q;

   // Feed control: read side first, then the write-side frame check overrides.
   always_comb begin
      state_d         = state_q;
      wr_pix_d        = wr_pix_q;
      rd_pix_d        = rd_pix_q;
      frame_cnt_d     = frame_cnt_q;
      underflow_cnt_d = underflow_cnt_q;
      underflow_d     = underflow_q;
      sync_err_d      = sync_err_q;
      fifo_wr         = 1'b0;
      fifo_rd         = 1'b0;
      fifo_flush      = 1'b0;

      if (clr_status) begin
         underflow_d = 1'b0;
         sync_err_d  = 1'b0;
      end

      if (!enable) begin
         fifo_flush = 1'b1;
         state_d    = SEEK;
         wr_pix_d   = '0;
         rd_pix_d   = '0;
      end else if (state_q == SEEK) begin
         if (accept && s.s_sof) begin
            fifo_wr  = 1'b1;
            wr_pix_d = 22'd1;
            state_d  = FILL;
         end
      end else begin
         if (state_q == FILL && (fifo_level >= PREFILL_L || full)) begin
            state_d = WAIT_FRAME;
         end
         if (start_hit) begin
            fifo_rd  = 1'b1;
            rd_pix_d = 22'd1;
            state_d  = STREAM;
         end
         if (state_q == STREAM && pixel_request && !empty) begin
            fifo_rd = 1'b1;
            if (rd_pix_q + 22'd1 == frame_size) begin
               rd_pix_d    = '0;
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end else begin
               rd_pix_d = rd_pix_q + 22'd1;
            end
         end

         if (underrun) begin
            underflow_d = 1'b1;
            if (underflow_cnt_q != '1) underflow_cnt_d = underflow_cnt_q + CNT_W'(1);
            fifo_flush = 1'b1;
            state_d    = SEEK;
            wr_pix_d   = '0;
            rd_pix_d   = '0;
         end else if (accept) begin
            if (frame_err) begin
               sync_err_d = 1'b1;
               fifo_flush = 1'b1;
               fifo_rd    = 1'b0;
               rd_pix_d   = '0;
               if (s.s_sof) begin
                  fifo_wr  = 1'b1;
                  wr_pix_d = 22'd1;
                  state_d  = FILL;
               end else begin
                  wr_pix_d = '0;
                  state_d  = SEEK;
               end
            end else begin
               fifo_wr  = 1'b1;
               wr_pix_d = s.s_sof ? 22'd1 : wr_pix_q + 22'd1;
            end
         end
      end
   end

   // Control and status registers, falling-edge with async reset.
   always_ff @(negedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= SEEK;
         wr_pix_q        <= '0;
         rd_pix_q        <= '0;
         frame_cnt_q     <= '0;
         underflow_cnt_q <= '0;
         underflow_q     <= 1'b0;
         sync_err_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         wr_pix_q        <= wr_pix_d;
         rd_pix_q        <= rd_pix_d;
         frame_cnt_q     <= frame_cnt_d;
         underflow_cnt_q <= underflow_cnt_d;
         underflow_q     <= underflow_d;
         sync_err_q      <= sync_err_d;
      end
   end

endmodule
